// File: rtl/or1200_keystream_xor.sv
// Keystream XOR stage for the AES-OFB pad generator: double-buffers pads
// and XORs 32-bit data words against successive pad words.
module or1200_keystream_xor #(
    parameter logic [7:0] SV_LOAD = 8'h02,
    parameter int         SV_STEP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] enc_pad,
    input  logic         enc_done,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    input  logic         out_ready,
    output logic         ks_stall,
    output logic [7:0]   shifted_value,
    output logic         overrun
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [127:0] cur_pad_q, cur_pad_d;
    logic [127:0] nxt_pad_q, nxt_pad_d;
    logic         nxt_valid_q, nxt_valid_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_data_q, out_data_d;
    logic         overrun_q, overrun_d;
    logic [1:0]   word_ptr_q, word_ptr_d;
    logic [7:0]   sv_q, sv_d;
    logic         accept;
    logic         exhaust;

    assign in_ready      = (state_q == ST_ACTIVE) & (~out_valid_q | out_ready);
    assign accept        = in_valid & in_ready;
    assign exhaust       = accept & (word_ptr_q == 2'd3);
    assign ks_stall      = in_valid & ~in_ready;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign shifted_value = sv_q;
    assign overrun       = overrun_q;

    always_comb begin
        state_d     = state_q;
        cur_pad_d   = cur_pad_q;
        nxt_pad_d   = nxt_pad_q;
        nxt_valid_d = nxt_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
        word_ptr_d  = word_ptr_q;
        sv_d        = sv_q;
        if (flush) begin
            // A pad arriving alongside flush belongs to the old seed: drop it.
            state_d     = ST_EMPTY;
            nxt_valid_d = 1'b0;
            out_valid_d = 1'b0;
            word_ptr_d  = 2'd0;
            sv_d        = 8'h00;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data ^ cur_pad_q[32*word_ptr_q +: 32];
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (state_q == ST_ACTIVE) begin
                if (accept && word_ptr_q != 2'd3) begin
                    word_ptr_d = word_ptr_q + 2'd1;
                    sv_d       = sv_q << SV_STEP;
                end
                if (exhaust) begin
                    word_ptr_d = 2'd0;
                    if (nxt_valid_q) begin
                        cur_pad_d   = nxt_pad_q;
                        nxt_valid_d = 1'b0;
                        sv_d        = SV_LOAD;
                    end else if (enc_done) begin
                        cur_pad_d = enc_pad;
                        sv_d      = SV_LOAD;
                    end else begin
                        state_d = ST_DRAIN;
                        sv_d    = 8'h00;
                    end
                end
                // The buffer frees this cycle on an exhaust swap, so no overrun.
                if (enc_done && !(exhaust && !nxt_valid_q)) begin
                    nxt_pad_d   = enc_pad;
                    nxt_valid_d = 1'b1;
                    if (nxt_valid_q && !exhaust) begin
                        overrun_d = 1'b1;
                    end
                end
            end else if (enc_done) begin
                cur_pad_d  = enc_pad;
                word_ptr_d = 2'd0;
                sv_d       = SV_LOAD;
                state_d    = ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            cur_pad_q   <= '0;
            nxt_pad_q   <= '0;
            nxt_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
            word_ptr_q  <= 2'd0;
            sv_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            cur_pad_q   <= cur_pad_d;
            nxt_pad_q   <= nxt_pad_d;
            nxt_valid_q <= nxt_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
            word_ptr_q  <= word_ptr_d;
            sv_q        <= sv_d;
        end
    end

endmodule

// File: tb/tb_or1200_keystream_xor.sv
// Directed vector bench for or1200_keystream_xor.
module tb_or1200_keystream_xor;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] enc_pad;
    logic         enc_done;
    logic         flush;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready;
    logic         ks_stall;
    logic [7:0]   shifted_value;
    logic         overrun;

    or1200_keystream_xor dut (
        .clk(clk), .rst(rst), .enc_pad(enc_pad), .enc_done(enc_done),
        .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .ks_stall(ks_stall),
        .shifted_value(shifted_value), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [31:0]  id;
        logic         ed;
        logic [127:0] pad;
        logic         fl;
        logic         ordy;
        logic         rdy;
        logic         ov;
        logic [31:0]  od;
        logic [7:0]   sv;
        logic         ovr;
    } vec_t;

    localparam logic [127:0] P1 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] P2 = 128'h44444444_55555555_66666666_77777777;
    localparam logic [127:0] P3 = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
    localparam logic [127:0] P4 = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
    localparam logic [127:0] P5 = {4{32'h0BAD0BAD}};
    localparam logic [127:0] P6 = 128'h66660003_66660002_66660001_66660000;
    localparam logic [127:0] P7 = {4{32'h77777777}};

    int n_vec = 0;
    int n_err = 0;
    vec_t tv[$];

    task automatic chk(input string name, input int idx,
                       input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s v%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] id, input logic ed,
                       input logic [127:0] pad, input logic fl, input logic ordy,
                       input logic rdy, input logic ov, input logic [31:0] od,
                       input logic [7:0] sv, input logic ovr);
        vec_t v;
        v.iv = iv; v.id = id; v.ed = ed; v.pad = pad; v.fl = fl;
        v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.od = od; v.sv = sv;
        v.ovr = ovr;
        tv.push_back(v);
    endtask

    initial begin
        // iv id ed pad fl ordy | rdy ov od sv ovr
        add(0, 32'h0, 1, P1, 0, 1,  0, 0, 32'h00000000, 8'h02, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 0, 1,  1, 1, 32'hFFFFFFFF, 8'h08, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 0, 1,  1, 1, 32'hEEEEEEEE, 8'h20, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 0, 1,  1, 1, 32'hDDDDDDDD, 8'h80, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 0, 1,  1, 1, 32'hCCCCCCCC, 8'h00, 0);
        add(1, 32'h12345678, 0, 0, 0, 1,  0, 0, 32'hCCCCCCCC, 8'h00, 0);
        add(1, 32'h12345678, 0, 0, 0, 1,  0, 0, 32'hCCCCCCCC, 8'h00, 0);
        add(1, 32'h12345678, 1, P2, 0, 1, 0, 0, 32'hCCCCCCCC, 8'h02, 0);
        add(1, 32'h12345678, 0, 0, 0, 1,  1, 1, 32'h6543210F, 8'h08, 0);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h66666666, 8'h20, 0);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h55555555, 8'h80, 0);
        add(0, 32'h0, 1, P3, 0, 1, 1, 0, 32'h55555555, 8'h80, 0);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h44444444, 8'h02, 0);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h0C0C0C0C, 8'h08, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 0, 1,  1, 1, 32'hF2F2F2F2, 8'h20, 0);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h0E0E0E0E, 8'h80, 0);
        add(1, 32'h0, 1, P4, 0, 1, 1, 1, 32'h0F0F0F0F, 8'h02, 0);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h89ABCDEF, 8'h08, 0);
        add(0, 32'h0, 1, P5, 0, 1, 1, 0, 32'h89ABCDEF, 8'h08, 0);
        add(0, 32'h0, 1, P6, 0, 1, 1, 0, 32'h89ABCDEF, 8'h08, 1);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h01234567, 8'h20, 1);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'hCAFEBABE, 8'h80, 1);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'hDEADBEEF, 8'h02, 1);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h66660000, 8'h08, 1);
        add(1, 32'h0, 0, 0, 0, 0,  0, 1, 32'h66660000, 8'h08, 1);
        add(1, 32'h0, 0, 0, 0, 0,  0, 1, 32'h66660000, 8'h08, 1);
        add(1, 32'h0, 0, 0, 0, 0,  0, 1, 32'h66660000, 8'h08, 1);
        add(1, 32'h0, 0, 0, 0, 1,  1, 1, 32'h66660001, 8'h20, 1);
        add(1, 32'h0, 1, P7, 1, 1, 1, 0, 32'h66660001, 8'h00, 1);
        add(1, 32'h0, 0, 0, 0, 1,  0, 0, 32'h66660001, 8'h00, 1);

        rst = 1'b0; enc_pad = '0; enc_done = 0; flush = 0;
        in_valid = 0; in_data = '0; out_ready = 1;
        #2;
        chk("rst_out_valid", -1, out_valid, 0);
        chk("rst_out_data", -1, out_data, 0);
        chk("rst_sv", -1, shifted_value, 0);
        chk("rst_overrun", -1, overrun, 0);
        chk("rst_in_ready", -1, in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        foreach (tv[i]) begin
            in_valid  = tv[i].iv;
            in_data   = tv[i].id;
            enc_done  = tv[i].ed;
            enc_pad   = tv[i].pad;
            flush     = tv[i].fl;
            out_ready = tv[i].ordy;
            @(negedge clk);
            chk("in_ready", i, in_ready, tv[i].rdy);
            chk("ks_stall", i, ks_stall, tv[i].iv & ~tv[i].rdy);
            @(posedge clk);
            #1;
            chk("out_valid", i, out_valid, tv[i].ov);
            chk("out_data", i, out_data, tv[i].od);
            chk("shifted_value", i, shifted_value, tv[i].sv);
            chk("overrun", i, overrun, tv[i].ovr);
        end

        in_valid = 0; enc_done = 0; flush = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_overrun", -2, overrun, 0);
        chk("rst2_out_data", -2, out_data, 0);
        chk("rst2_sv", -2, shifted_value, 0);
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_in_ready", -2, in_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
